prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial PRBS checker that sits directly downstream of the 8-bit Fibonacci LFSR generator and consumes its serial output bit stream.
- Self-synchronises to the stream and declares lock once enough consecutive bits match.
- While locked, it flywheels its own prediction, so each corrupted bit counts exactly once.
- Used for on-chip/bring-up BER checks of the generator and its pad path.

Parameters:
N, 8, history/LFSR length; must match generator
TAP_A, 5, second feedback index into history (h[N-1]^h[TAP_A]^h[TAP_B])
TAP_B, 3, third feedback index into history
LOCK_CNT, 16, consecutive matches in HUNT required to lock
WIN, 32, window length in valid bits for loss-of-lock evaluation
LOSS_THR, 8, mismatches within one window that force loss of lock
ERR_W, 16, error counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  bit_in valid this cycle; all state frozen when low
bit_in  input  1  serial bit from generator lfsr_out
clear_err  input  1  synchronous clear of err_count; lock state unaffected
locked  output  1  registered; high in LOCKED
err_pulse  output  1  registered; one-cycle pulse per counted mismatch
err_count  output  ERR_W  saturating mismatch count while LOCKED
state  output  2  current FSM state, for debug
io_oeb  output  1  constant 0 (outputs always driven)
- Power pins vccd1/vssd1 present under USE_POWER_PINS, as on all user-area blocks.

Behaviour:
- Reset (async): state=FILL, history h=0, fill/match/window/mismatch counters=0, locked=0, err_pulse=0, err_count=0.
- History h[N-1:0]: h[0] is the most recent accepted bit, h[k] is the bit accepted k+1 valid cycles earlier.
- Prediction p = h[N-1]^h[TAP_A]^h[TAP_B]. This equals the generator recurrence o(t)=o(t-8)^o(t-6)^o(t-4).
- Mismatch m = en & (bit_in != p); evaluated only in HUNT and LOCKED.
- Only cycles with en=1 advance anything.
- FILL (enc 0):
  - Shift bit_in into h; count N accepted bits, then go to HUNT.
- HUNT (enc 1):
  - Shift bit_in into h.
  - On a match, match_cnt increments; on mismatch, match_cnt clears.
  - match_cnt also clears whenever the post-shift h is all zeros, so the all-zero lock-up state never locks.
  - When match_cnt reaches LOCK_CNT, go to LOCKED on that edge and set locked=1 on the same edge.
  - Min lock latency from reset release with en=1 continuously: N+LOCK_CNT = 24 valid bits.
- LOCKED (enc 2):
  - Shift p (not bit_in) into h.
  - On mismatch: err_pulse=1 next cycle; err_count+1, saturating at 2^ERR_W-1; win_err+1.
  - win_cnt counts accepted bits 0..WIN-1. On wrap, win_err clears; a mismatch on the wrap cycle counts into the new window.
  - If win_err reaches LOSS_THR, go to HUNT: locked=0, match_cnt=0, win counters=0. h is kept, but the next bits shift in from bit_in.
  - err_count holds its value on loss of lock.
- Encoding 3 is illegal: recover to FILL on the next edge.
- clear_err: err_count=0 on the edge. If a mismatch occurs on the same edge, err_count=1 (increment wins over clear).
- en low: no shift, no counting, err_pulse=0.
- Reset mid-lock: immediate return to the reset values above.

Decomposition:
- Shared header prbs_defs.vh holds:
  - state encodings ST_FILL=0, ST_HUNT=1, ST_LOCKED=2;
  - default taps for N=8: 7/5/3;
  - default LOCK_CNT, WIN, LOSS_THR.
- The generator adopts the same tap macros.
- Sub-module sat_counter (parameter W; inputs clr, inc; output q; async reset) is used for err_count.
- The FSM, history and window logic stay in prbs_checker.

Test Plan:
- Generator seeded 8'hA5 via load, then free-run; checker with en=1 -> locked rises after exactly 24 bits, err_count stays 0 over 1000 bits.
- Locked; invert one bit_in -> err_pulse once, err_count=1, and no further errors (flywheel proves no error multiplication).
- Locked; invert 8 of 32 consecutive bits -> locked falls on the 8th mismatch; relocks 16 matching bits later; err_count=8 held.
- Constant bit_in=0 for 200 cycles -> never locks; state remains HUNT.
- en toggling 50% with the generator gated alike -> lock after 24 valid bits; gaps cause no errors; err_count pinned at 0xFFFF with forced errors and ERR_W=16; clear_err plus a simultaneous mismatch -> err_count=1.
- Assert reset while locked with err_count=5 -> all outputs 0 immediately (asynchronously), state=FILL.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker: state encodings and default
// parameters that must agree with the LFSR generator.
package prbs_checker_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Taps for the 8-bit generator recurrence o(t)=o(t-8)^o(t-6)^o(t-4)
    localparam int DEF_N        = 8;
    localparam int DEF_TAP_A    = 5;
    localparam int DEF_TAP_B    = 3;
    localparam int DEF_LOCK_CNT = 16;
    localparam int DEF_WIN      = 32;
    localparam int DEF_LOSS_THR = 8;
    localparam int DEF_ERR_W    = 16;

endpackage

// File: rtl/prbs_checker_if.sv
// Stream and status bundle between the PRBS checker and its host logic.
interface prbs_checker_if #(
    parameter int ERR_W = 16
);
    logic             en;
    logic             bit_in;
    logic             clear_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;
    logic             io_oeb;

    modport master (
        output en, bit_in, clear_err,
        input  locked, err_pulse, err_count, state, io_oeb
    );

    modport slave (
        input  en, bit_in, clear_err,
        output locked, err_pulse, err_count, state, io_oeb
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment coinciding
// with a clear leaves the count at one.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= W'(inc);
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker; flywheels its own prediction
// once locked so that each corrupted input bit is counted exactly once.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int TAP_A    = DEF_TAP_A,
    parameter int TAP_B    = DEF_TAP_B,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int WIN      = DEF_WIN,
    parameter int LOSS_THR = DEF_LOSS_THR,
    parameter int ERR_W    = DEF_ERR_W
) (
`ifdef USE_POWER_PINS
    inout wire             vccd1,
    inout wire             vssd1,
`endif
    input  logic           clk,
    input  logic           reset,
    prbs_checker_if.slave  bus
);

    localparam int FILL_W  = $clog2(N);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WCNT_W  = $clog2(WIN);
    localparam int WERR_W  = $clog2(LOSS_THR + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(N - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WCNT_W-1:0]  WIN_LAST   = WCNT_W'(WIN - 1);
    localparam logic [WERR_W-1:0]  LOSS_LVL   = WERR_W'(LOSS_THR);

    state_t              state_r;
    logic [N-1:0]        h;
    logic [FILL_W-1:0]   fill_cnt;
    logic [MATCH_W-1:0]  match_cnt;
    logic [WCNT_W-1:0]   win_cnt;
    logic [WERR_W-1:0]   win_err;
    logic                locked_r;
    logic                err_pulse_r;

    logic                p;
    logic                miss;
    logic [N-1:0]        h_shift;
    logic                win_wrap;
    logic [WERR_W-1:0]   win_err_next;
    logic                err_inc;

    assign p        = h[N-1] ^ h[TAP_A] ^ h[TAP_B];
    assign miss     = bus.bit_in != p;
    assign h_shift  = {h[N-2:0], bus.bit_in};
    assign win_wrap = (win_cnt == WIN_LAST);
    assign err_inc  = bus.en & miss & (state_r == ST_LOCKED);

    // A mismatch on the wrap cycle is the first count of the new window
    always_comb begin
        win_err_next = win_wrap ? '0 : win_err;
        win_err_next = win_err_next + WERR_W'(miss);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_FILL;
            h           <= '0;
            fill_cnt    <= '0;
            match_cnt   <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
        end else begin
            err_pulse_r <= 1'b0;
            case (state_r)
                ST_FILL: begin
                    if (bus.en) begin
                        h <= h_shift;
                        if (fill_cnt == FILL_LAST) begin
                            fill_cnt <= '0;
                            state_r  <= ST_HUNT;
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end
                end
                ST_HUNT: begin
                    if (bus.en) begin
                        h <= h_shift;
                        // An all-zero history is the LFSR lock-up state; never lock on it
                        if (miss || (h_shift == '0)) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                            locked_r  <= 1'b1;
                            state_r   <= ST_LOCKED;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bus.en) begin
                        h           <= {h[N-2:0], p};
                        err_pulse_r <= miss;
                        if (win_err_next == LOSS_LVL) begin
                            win_cnt   <= '0;
                            win_err   <= '0;
                            match_cnt <= '0;
                            locked_r  <= 1'b0;
                            state_r   <= ST_HUNT;
                        end else begin
                            win_cnt <= win_wrap ? '0 : win_cnt + WCNT_W'(1);
                            win_err <= win_err_next;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_FILL;
                    fill_cnt  <= '0;
                    match_cnt <= '0;
                    win_cnt   <= '0;
                    win_err   <= '0;
                    locked_r  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(ERR_W)) u_err_count (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear_err),
        .inc   (err_inc),
        .q     (bus.err_count)
    );

    assign bus.locked    = locked_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.state     = state_r;
    assign bus.io_oeb    = 1'b0;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a behavioural model of the 8-bit
// generator feeds a 16-bit-count checker and a 4-bit-count twin in parallel.
module tb_prbs_checker;
    import prbs_checker_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic en_v, bit_v, clr_v;

    always #5 clk = ~clk;

    prbs_checker_if #(.ERR_W(16)) bus   ();
    prbs_checker_if #(.ERR_W(4))  bus_s ();

    assign bus.en          = en_v;
    assign bus.bit_in      = bit_v;
    assign bus.clear_err   = clr_v;
    assign bus_s.en        = en_v;
    assign bus_s.bit_in    = bit_v;
    assign bus_s.clear_err = clr_v;

    prbs_checker #(.ERR_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    prbs_checker #(.ERR_W(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    int          tests = 0;
    int          fails = 0;
    int          pulses;
    logic        lock_seen;
    logic  [7:0] gh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change at the falling edge, outputs sampled 1ns after the rising edge
    task automatic drive(input logic e, input logic b, input logic clr);
        @(negedge clk);
        en_v  = e;
        bit_v = b;
        clr_v = clr;
        @(posedge clk);
        #1;
        if (bus.err_pulse === 1'b1) pulses++;
        if (bus.locked === 1'b1) lock_seen = 1'b1;
    endtask

    // Generator bit, optionally inverted on the pad path; generator only advances when valid
    task automatic send(input logic e, input logic inv, input logic clr);
        logic nb;
        nb = gh[7] ^ gh[5] ^ gh[3];
        if (e) begin
            drive(1'b1, nb ^ inv, clr);
            gh = {gh[6:0], nb};
        end else begin
            drive(1'b0, 1'($urandom_range(1)), clr);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en_v  = 1'b0;
        bit_v = 1'b0;
        clr_v = 1'b0;
        gh    = 8'hA5;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        pulses    = 0;
        lock_seen = 1'b0;
    endtask

    initial begin
        // Lock from reset and long error-free run
        do_reset();
        check("rst_locked", bus.locked, 0);
        check("rst_state", bus.state, ST_FILL);
        check("rst_err_count", bus.err_count, 0);
        check("rst_err_pulse", bus.err_pulse, 0);
        check("io_oeb", bus.io_oeb, 0);
        repeat (8) send(1'b1, 1'b0, 1'b0);
        check("hunt_after_fill", bus.state, ST_HUNT);
        repeat (15) send(1'b1, 1'b0, 1'b0);
        check("unlocked_at_23", bus.locked, 0);
        send(1'b1, 1'b0, 1'b0);
        check("locked_at_24", bus.locked, 1);
        check("state_locked", bus.state, ST_LOCKED);
        repeat (1000) send(1'b1, 1'b0, 1'b0);
        check("clean_err_count", bus.err_count, 0);
        check("clean_pulses", pulses, 0);
        check("clean_locked", bus.locked, 1);

        // Single corrupted bit is counted once
        pulses = 0;
        send(1'b1, 1'b1, 1'b0);
        check("single_pulse", bus.err_pulse, 1);
        check("single_count", bus.err_count, 1);
        repeat (50) send(1'b1, 1'b0, 1'b0);
        check("single_no_mult", bus.err_count, 1);
        check("single_pulses", pulses, 1);
        check("single_locked", bus.locked, 1);

        // 1051 locked bits so far: 5 more reach the window boundary; clear on the last
        repeat (4) send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        check("clear_err", bus.err_count, 0);
        check("clear_keeps_lock", bus.locked, 1);
        repeat (7) send(1'b1, 1'b1, 1'b0);
        check("seven_still_locked", bus.locked, 1);
        send(1'b1, 1'b1, 1'b0);
        check("loss_on_8th", bus.locked, 0);
        check("loss_state", bus.state, ST_HUNT);
        check("loss_count", bus.err_count, 8);
        repeat (15) send(1'b1, 1'b0, 1'b0);
        check("relock_not_yet", bus.locked, 0);
        send(1'b1, 1'b0, 1'b0);
        check("relock_at_16", bus.locked, 1);
        check("count_held", bus.err_count, 8);

        // Sparse errors (one per 5 bits) never lose lock; 4-bit twin saturates
        for (int i = 0; i < 100; i++) send(1'b1, 1'((i % 5) == 4), 1'b0);
        check("sparse_locked", bus.locked, 1);
        check("sparse_count16", bus.err_count, 28);
        check("sat_count4", bus_s.err_count, 15);
        send(1'b1, 1'b1, 1'b1);
        check("clr_inc_16", bus.err_count, 1);
        check("clr_inc_4", bus_s.err_count, 1);
        check("clr_inc_pulse", bus.err_pulse, 1);

        // Constant zero input must never lock
        do_reset();
        repeat (200) drive(1'b1, 1'b0, 1'b0);
        check("zero_never_locked", lock_seen, 0);
        check("zero_state_hunt", bus.state, ST_HUNT);
        check("zero_no_pulses", pulses, 0);

        // Gapped stream: lock counted in valid bits only
        do_reset();
        for (int i = 0; i < 23; i++) begin
            send(1'b0, 1'b0, 1'b0);
            send(1'b1, 1'b0, 1'b0);
        end
        check("gap_unlocked_23", bus.locked, 0);
        send(1'b0, 1'b0, 1'b0);
        check("gap_frozen", bus.locked, 0);
        send(1'b1, 1'b0, 1'b0);
        check("gap_locked_24", bus.locked, 1);
        for (int i = 0; i < 100; i++) send(1'(i % 2), 1'b0, 1'b0);
        check("gap_no_errors", bus.err_count, 0);
        check("gap_no_pulses", pulses, 0);

        // Reset while locked clears everything asynchronously
        for (int i = 0; i < 25; i++) send(1'b1, 1'((i % 5) == 4), 1'b0);
        check("pre_rst_count", bus.err_count, 5);
        check("pre_rst_pulse", bus.err_pulse, 1);
        check("pre_rst_locked", bus.locked, 1);
        #2 reset = 1'b1;
        #1;
        check("async_locked", bus.locked, 0);
        check("async_count", bus.err_count, 0);
        check("async_pulse", bus.err_pulse, 0);
        check("async_state", bus.state, ST_FILL);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
